// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, flag bit
// positions, instruction field helpers and the ALU opcode map used by the
// operand mux, the flag unit and the write-back logic.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Flag register layout {CA,CB,ZA,ZB,NA,NB}
  localparam int FLAG_CA = 5;
  localparam int FLAG_CB = 4;
  localparam int FLAG_ZA = 3;
  localparam int FLAG_ZB = 2;
  localparam int FLAG_NA = 1;
  localparam int FLAG_NB = 0;

  // Instruction fields: [15:10] opcode, [9:8] unused, [7:0] immediate
  localparam int OP_W   = 6;
  localparam int IMM_W  = 8;

  // ALU opcodes
  localparam logic [5:0] OP_ADDA  = 6'h00;
  localparam logic [5:0] OP_ADDB  = 6'h01;
  localparam logic [5:0] OP_SUBA  = 6'h02;
  localparam logic [5:0] OP_SUBB  = 6'h03;
  localparam logic [5:0] OP_ANDA  = 6'h04;
  localparam logic [5:0] OP_ANDB  = 6'h05;
  localparam logic [5:0] OP_ORA   = 6'h06;
  localparam logic [5:0] OP_ORB   = 6'h07;
  localparam logic [5:0] OP_ADDCA = 6'h08;
  localparam logic [5:0] OP_ADDCB = 6'h09;
  localparam logic [5:0] OP_SUBCA = 6'h0A;
  localparam logic [5:0] OP_SUBCB = 6'h0B;
  localparam logic [5:0] OP_ANDCA = 6'h0C;
  localparam logic [5:0] OP_ANDCB = 6'h0D;
  localparam logic [5:0] OP_ORCA  = 6'h0E;
  localparam logic [5:0] OP_ORCB  = 6'h0F;
  localparam logic [5:0] OP_SHLA  = 6'h10;
  localparam logic [5:0] OP_SHRA  = 6'h11;
  localparam logic [5:0] OP_JMP   = 6'h18;
  localparam logic [5:0] OP_BAEQ  = 6'h19;
  localparam logic [5:0] OP_BANE  = 6'h1A;
  localparam logic [5:0] OP_BBEQ  = 6'h1B;
  localparam logic [5:0] OP_BBNE  = 6'h1C;
  localparam logic [5:0] OP_NOP   = 6'h30;

  function automatic logic op_dest_a(input logic [5:0] op);
    return op inside {OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA,
                      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA,
                      OP_SHLA, OP_SHRA};
  endfunction

  function automatic logic op_dest_b(input logic [5:0] op);
    return op inside {OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB,
                      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB};
  endfunction

  function automatic logic op_is_add(input logic [5:0] op);
    return op inside {OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB};
  endfunction

  function automatic logic op_is_sub(input logic [5:0] op);
    return op inside {OP_SUBA, OP_SUBB, OP_SUBCA, OP_SUBCB};
  endfunction

  function automatic logic op_is_branch(input logic [5:0] op);
    return op inside {OP_JMP, OP_BAEQ, OP_BANE, OP_BBEQ, OP_BBNE};
  endfunction

endpackage

// File: rtl/alu_sequencer_flag_unit.sv
// Combinational flag candidate generator.
//  i_op       : opcode of the executing instruction
//  i_oper1/2  : operands presented to the ALU
//  i_result   : ALU result
//  o_flags_nxt: candidate values in {CA,CB,ZA,ZB,NA,NB} layout
//  o_flags_we : per-flag write enables (only the destination's flags; C only
//               for add/sub, so logic ops and shifts preserve carry)
module alu_sequencer_flag_unit
  import alu_sequencer_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [7:0] i_oper1,
  input  logic [7:0] i_oper2,
  input  logic [7:0] i_result,
  output logic [5:0] o_flags_nxt,
  output logic [5:0] o_flags_we
);

  logic [8:0] w_sum;
  logic       w_dest_a, w_dest_b, w_arith, w_carry;

  assign w_sum    = {1'b0, i_oper1} + {1'b0, i_oper2};
  assign w_dest_a = op_dest_a(i_op);
  assign w_dest_b = op_dest_b(i_op);
  assign w_arith  = op_is_add(i_op) | op_is_sub(i_op);

  // A-side subtracts compute oper1-oper2, B-side compute oper2-oper1;
  // carry on subtract is the borrow (minuend < subtrahend).
  assign w_carry = op_is_add(i_op) ? w_sum[8] :
                   w_dest_a        ? (i_oper1 < i_oper2) :
                                     (i_oper2 < i_oper1);

  always_comb begin
    o_flags_nxt = '0;
    o_flags_we  = '0;
    if (w_dest_a) begin
      o_flags_nxt[FLAG_CA] = w_carry;
      o_flags_nxt[FLAG_ZA] = ~|i_result;
      o_flags_nxt[FLAG_NA] = i_result[7];
      o_flags_we[FLAG_CA]  = w_arith;
      o_flags_we[FLAG_ZA]  = 1'b1;
      o_flags_we[FLAG_NA]  = 1'b1;
    end
    if (w_dest_b) begin
      o_flags_nxt[FLAG_CB] = w_carry;
      o_flags_nxt[FLAG_ZB] = ~|i_result;
      o_flags_nxt[FLAG_NB] = i_result[7];
      o_flags_we[FLAG_CB]  = w_arith;
      o_flags_we[FLAG_ZB]  = 1'b1;
      o_flags_we[FLAG_NB]  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of an external ALU. Runs FETCH->DECODE->EXEC->WB per
// instruction, holding PC, IR, accumulators A/B and the CZN flags.
//  iClock/iReset          : clock, synchronous active-low reset
//  oInstReq/oInstAddr     : fetch request (held until iInstValid) and PC
//  iInstValid/iInstData   : fetched instruction, accepted only in FETCH
//  oAluOper1/2,oAluInstSel: registered ALU inputs, valid DECODE..EXEC
//  iAluData/iAluBranchTaken: ALU result and branch decision, sampled in EXEC
//  oAccA/oAccB/oFlags     : architectural state
//  oInstDone              : one-cycle pulse in WB
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  INST_WIDTH = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  output logic                  oInstReq,
  output logic [PC_WIDTH-1:0]   oInstAddr,
  input  logic                  iInstValid,
  input  logic [INST_WIDTH-1:0] iInstData,
  output logic [7:0]            oAluOper1,
  output logic [7:0]            oAluOper2,
  output logic [5:0]            oAluInstSel,
  input  logic [7:0]            iAluData,
  input  logic                  iAluBranchTaken,
  output logic [7:0]            oAccA,
  output logic [7:0]            oAccB,
  output logic [5:0]            oFlags,
  output logic                  oInstDone
);

  state_e                r_state;
  logic                  r_instReq, r_instDone, r_branch;
  logic [INST_WIDTH-1:0] r_ir;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [7:0]            r_accA, r_accB, r_oper1, r_oper2, r_result;
  logic [5:0]            r_aluSel, r_flags, r_flagNxt, r_flagWe;

  logic [5:0] w_op_in, w_op_ir, w_flagNxt, w_flagWe;
  logic [7:0] w_imm_in, w_imm_ir, w_oper1, w_oper2;
  logic       w_unused_ir;

  assign w_op_in     = iInstData[INST_WIDTH-1 -: OP_W];
  assign w_imm_in    = iInstData[IMM_W-1:0];
  assign w_op_ir     = r_ir[INST_WIDTH-1 -: OP_W];
  assign w_imm_ir    = r_ir[IMM_W-1:0];
  assign w_unused_ir = ^r_ir[INST_WIDTH-OP_W-1:IMM_W];

  // Operand mux, registered on the FETCH->DECODE edge from the incoming word
  always_comb begin
    w_oper1 = '0;
    w_oper2 = '0;
    case (w_op_in)
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA,
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        w_oper1 = r_accA;
        w_oper2 = r_accB;
      end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin
        w_oper1 = r_accA;
        w_oper2 = w_imm_in;
      end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin
        w_oper1 = w_imm_in;
        w_oper2 = r_accB;
      end
      OP_SHLA, OP_SHRA: w_oper1 = r_accA;
      default: ;
    endcase
  end

  alu_sequencer_flag_unit u_flag_unit (
    .i_op        (w_op_ir),
    .i_oper1     (r_oper1),
    .i_oper2     (r_oper2),
    .i_result    (iAluData),
    .o_flags_nxt (w_flagNxt),
    .o_flags_we  (w_flagWe)
  );

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_state    <= ST_FETCH;
      r_instReq  <= 1'b0;
      r_instDone <= 1'b0;
      r_branch   <= 1'b0;
      r_ir       <= '0;
      r_pc       <= RESET_PC;
      r_accA     <= '0;
      r_accB     <= '0;
      r_oper1    <= '0;
      r_oper2    <= '0;
      r_result   <= '0;
      r_aluSel   <= '0;
      r_flags    <= '0;
      r_flagNxt  <= '0;
      r_flagWe   <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // Request goes up the cycle after reset; a word is only taken
          // while the request is visible to the memory side.
          r_instReq <= 1'b1;
          if (r_instReq && iInstValid) begin
            r_instReq <= 1'b0;
            r_ir      <= iInstData;
            r_aluSel  <= w_op_in;
            r_oper1   <= w_oper1;
            r_oper2   <= w_oper2;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_result   <= iAluData;
          r_branch   <= iAluBranchTaken;
          r_flagNxt  <= w_flagNxt;
          r_flagWe   <= w_flagWe;
          r_aluSel   <= '0;
          r_oper1    <= '0;
          r_oper2    <= '0;
          r_instDone <= 1'b1;
          r_state    <= ST_WB;
        end
        ST_WB: begin
          if (op_dest_a(w_op_ir)) r_accA <= r_result;
          if (op_dest_b(w_op_ir)) r_accB <= r_result;
          r_flags <= (r_flags & ~r_flagWe) | (r_flagNxt & r_flagWe);
          if (op_is_branch(w_op_ir) && r_branch)
            r_pc <= PC_WIDTH'(w_imm_ir);
          else
            r_pc <= r_pc + PC_WIDTH'(1);
          r_instDone <= 1'b0;
          r_instReq  <= 1'b1;
          r_state    <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign oInstReq    = r_instReq;
  assign oInstAddr   = r_pc;
  assign oAluOper1   = r_oper1;
  assign oAluOper2   = r_oper2;
  assign oAluInstSel = r_aluSel;
  assign oAccA       = r_accA;
  assign oAccB       = r_accB;
  assign oFlags      = r_flags;
  assign oInstDone   = r_instDone;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized checks of alu_sequencer against an arithmetic
// reference model of the instruction set; an ALU stub answers the sequencer.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iInstValid = 1'b0;
  logic [15:0] iInstData = '0;
  logic [7:0]  iAluData;
  logic        iAluBranchTaken;
  logic        oInstReq, oInstDone;
  logic [7:0]  oInstAddr, oAluOper1, oAluOper2, oAccA, oAccB;
  logic [5:0]  oAluInstSel, oFlags;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference architectural state
  logic [7:0] m_a, m_b, m_pc;
  logic [5:0] m_f;

  alu_sequencer dut (
    .iClock(iClock), .iReset(iReset),
    .oInstReq(oInstReq), .oInstAddr(oInstAddr),
    .iInstValid(iInstValid), .iInstData(iInstData),
    .oAluOper1(oAluOper1), .oAluOper2(oAluOper2), .oAluInstSel(oAluInstSel),
    .iAluData(iAluData), .iAluBranchTaken(iAluBranchTaken),
    .oAccA(oAccA), .oAccB(oAccB), .oFlags(oFlags), .oInstDone(oInstDone)
  );

  always #5 iClock = ~iClock;
  always @(posedge iClock) cyc <= cyc + 1;

  // ALU stub: B-side subtracts give oper2-oper1
  always_comb begin
    iAluData = 8'h00;
    iAluBranchTaken = 1'b0;
    case (oAluInstSel)
      OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB: iAluData = oAluOper1 + oAluOper2;
      OP_SUBA, OP_SUBCA: iAluData = oAluOper1 - oAluOper2;
      OP_SUBB, OP_SUBCB: iAluData = oAluOper2 - oAluOper1;
      OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: iAluData = oAluOper1 & oAluOper2;
      OP_ORA, OP_ORB, OP_ORCA, OP_ORCB: iAluData = oAluOper1 | oAluOper2;
      OP_SHLA: iAluData = oAluOper1 << 1;
      OP_SHRA: iAluData = oAluOper1 >> 1;
      OP_JMP:  iAluBranchTaken = 1'b1;
      OP_BAEQ: iAluBranchTaken = oFlags[FLAG_ZA];
      OP_BANE: iAluBranchTaken = ~oFlags[FLAG_ZA];
      OP_BBEQ: iAluBranchTaken = oFlags[FLAG_ZB];
      OP_BBNE: iAluBranchTaken = ~oFlags[FLAG_ZB];
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [7:0] imm);
    logic [1:0] pad;
    pad = 2'($urandom);
    return {op, pad, imm};
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_pc = 8'h00; m_f = 6'h00;
  endtask

  task automatic set_acc(input bit dst_b, input int v, input bit upd_c, input bit c);
    logic [7:0] r;
    r = 8'(v);
    if (!dst_b) begin
      m_a = r; m_f[FLAG_ZA] = (r == 8'h00); m_f[FLAG_NA] = r[7];
      if (upd_c) m_f[FLAG_CA] = c;
    end else begin
      m_b = r; m_f[FLAG_ZB] = (r == 8'h00); m_f[FLAG_NB] = r[7];
      if (upd_c) m_f[FLAG_CB] = c;
    end
  endtask

  // Operands the ALU should see for an instruction, from the current model state
  task automatic exp_operands(input logic [5:0] op, input logic [7:0] imm,
                              output logic [7:0] o1, output logic [7:0] o2);
    o1 = 8'h00; o2 = 8'h00;
    case (op)
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA, OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin o1 = m_a; o2 = m_b; end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin o1 = m_a; o2 = imm; end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin o1 = imm; o2 = m_b; end
      OP_SHLA, OP_SHRA: o1 = m_a;
      default: ;
    endcase
  endtask

  task automatic model_step(input logic [15:0] inst);
    logic [5:0] op;
    int a, b, i;
    bit taken;
    op = inst[15:10]; i = int'(inst[7:0]); a = int'(m_a); b = int'(m_b);
    taken = 1'b0;
    case (op)
      OP_ADDA:  set_acc(0, a + b, 1, (a + b) > 255);
      OP_SUBA:  set_acc(0, a - b, 1, a < b);
      OP_ANDA:  set_acc(0, a & b, 0, 0);
      OP_ORA:   set_acc(0, a | b, 0, 0);
      OP_ADDCA: set_acc(0, a + i, 1, (a + i) > 255);
      OP_SUBCA: set_acc(0, a - i, 1, a < i);
      OP_ANDCA: set_acc(0, a & i, 0, 0);
      OP_ORCA:  set_acc(0, a | i, 0, 0);
      OP_SHLA:  set_acc(0, a * 2, 0, 0);
      OP_SHRA:  set_acc(0, a / 2, 0, 0);
      OP_ADDB:  set_acc(1, a + b, 1, (a + b) > 255);
      OP_SUBB:  set_acc(1, b - a, 1, b < a);
      OP_ANDB:  set_acc(1, a & b, 0, 0);
      OP_ORB:   set_acc(1, a | b, 0, 0);
      OP_ADDCB: set_acc(1, i + b, 1, (i + b) > 255);
      OP_SUBCB: set_acc(1, b - i, 1, b < i);
      OP_ANDCB: set_acc(1, i & b, 0, 0);
      OP_ORCB:  set_acc(1, i | b, 0, 0);
      OP_JMP:   taken = 1'b1;
      OP_BAEQ:  taken = m_f[FLAG_ZA];
      OP_BANE:  taken = !m_f[FLAG_ZA];
      OP_BBEQ:  taken = m_f[FLAG_ZB];
      OP_BBNE:  taken = !m_f[FLAG_ZB];
      default: ;
    endcase
    m_pc = taken ? inst[7:0] : 8'(int'(m_pc) + 1);
  endtask

  task automatic do_reset();
    iReset = 1'b0; iInstValid = 1'b0;
    @(posedge iClock); #1;
    iReset = 1'b1;
    model_reset();
    chk("rst_req", oInstReq, 0);
    chk("rst_done", oInstDone, 0);
    chk("rst_pc", oInstAddr, 0);
    chk("rst_acc", {oAccA, oAccB}, 0);
    chk("rst_flags", oFlags, 0);
  endtask

  // One full instruction: wait for request, hold off wt cycles, present the
  // word, then check DECODE outputs, latency, the done pulse and final state.
  task automatic run_inst(input logic [15:0] inst, input int wt);
    int n, t0;
    logic [7:0] e1, e2;
    n = 0;
    while (oInstReq !== 1'b1 && n < 50) begin @(posedge iClock); #1; n++; end
    chk("req_seen", oInstReq, 1);
    chk("inst_addr", oInstAddr, m_pc);
    t0 = cyc;
    repeat (wt) begin @(posedge iClock); #1; end
    iInstValid = 1'b1; iInstData = inst;
    @(posedge iClock); #1;
    iInstValid = 1'b0; iInstData = 16'($urandom);
    exp_operands(inst[15:10], inst[7:0], e1, e2);
    chk("dec_sel", oAluInstSel, inst[15:10]);
    chk("dec_oper1", oAluOper1, e1);
    chk("dec_oper2", oAluOper2, e2);
    n = 0;
    while (oInstDone !== 1'b1 && n < 20) begin
      @(posedge iClock); #1; n++;
      // Valid outside FETCH must be ignored
      iInstValid = 1'($urandom); iInstData = 16'($urandom);
    end
    iInstValid = 1'b0;
    chk("done_seen", oInstDone, 1);
    // Cycles counted inclusively from the one where oInstReq was seen high
    chk("latency", cyc - t0 + 1, wt + 4);
    model_step(inst);
    @(posedge iClock); #1;
    chk("done_pulse", oInstDone, 0);
    chk("sel_idle", oAluInstSel, 0);
    chk("accA", oAccA, m_a);
    chk("accB", oAccB, m_b);
    chk("flags", oFlags, m_f);
    chk("pc", oInstAddr, m_pc);
  endtask

  initial begin
    logic [5:0] ops [24];
    bit saw_done;
    ops = '{OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB, OP_ORA, OP_ORB,
            OP_ADDCA, OP_ADDCB, OP_SUBCA, OP_SUBCB, OP_ANDCA, OP_ANDCB, OP_ORCA, OP_ORCB,
            OP_SHLA, OP_SHRA, OP_JMP, OP_BAEQ, OP_BANE, OP_BBEQ, OP_NOP, 6'h3F};
    model_reset();
    repeat (2) @(posedge iClock);
    #1;

    // 1: first instruction after reset with a 3-cycle fetch wait
    do_reset();
    run_inst(mk(OP_ADDCA, 8'h05), 3);
    chk("t1_A", oAccA, 8'h05);
    chk("t1_ZA_NA", {oFlags[FLAG_ZA], oFlags[FLAG_NA]}, 0);
    chk("t1_pc", oInstAddr, 8'h01);

    // 2: A=FF + 1 wraps with carry; B side untouched
    run_inst(mk(OP_ADDCA, 8'hFA), 0);
    run_inst(mk(OP_ADDCA, 8'h01), 1);
    chk("t2_A", oAccA, 8'h00);
    chk("t2_CA_ZA_NA", {oFlags[FLAG_CA], oFlags[FLAG_ZA], oFlags[FLAG_NA]}, 3'b110);
    chk("t2_B", oAccB, 8'h00);
    chk("t2_Bflags", {oFlags[FLAG_CB], oFlags[FLAG_ZB], oFlags[FLAG_NB]}, 0);

    // 3: B-side subtracts
    do_reset();
    run_inst(mk(OP_ADDCA, 8'h03), 0);
    run_inst(mk(OP_ADDCB, 8'h05), 2);
    run_inst(mk(OP_SUBB, 8'h00), 0);
    chk("t3_subb_B", oAccB, 8'h02);
    chk("t3_subb_CB", oFlags[FLAG_CB], 0);
    run_inst(mk(OP_SUBCB, 8'h03), 0);
    chk("t3_subcb_B", oAccB, 8'hFF);
    chk("t3_subcb_CB_NB", {oFlags[FLAG_CB], oFlags[FLAG_NB]}, 2'b11);

    // 4: branches and PC wrap
    do_reset();
    run_inst(mk(OP_ANDCA, 8'h00), 0);
    run_inst(mk(OP_BAEQ, 8'h40), 0);
    chk("t4_baeq_taken", oInstAddr, 8'h40);
    run_inst(mk(OP_ADDCA, 8'h01), 0);
    run_inst(mk(OP_JMP, 8'h10), 0);
    run_inst(mk(OP_BAEQ, 8'h40), 1);
    chk("t4_baeq_not", oInstAddr, 8'h11);
    run_inst(mk(OP_JMP, 8'hFF), 0);
    run_inst(mk(OP_NOP, 8'h00), 0);
    chk("t4_wrap", oInstAddr, 8'h00);

    // 5: logic op preserves carry; unknown opcode is a NOP
    do_reset();
    run_inst(mk(OP_ADDCA, 8'hFF), 0);
    run_inst(mk(OP_ADDCA, 8'h01), 0);
    run_inst(mk(OP_ORCA, 8'hF0), 0);
    run_inst(mk(OP_ANDCA, 8'h0F), 0);
    chk("t5_A", oAccA, 8'h00);
    chk("t5_CA_ZA", {oFlags[FLAG_CA], oFlags[FLAG_ZA]}, 2'b11);
    run_inst(mk(6'h3F, 8'h77), 0);
    chk("t5_unk_state", {oAccA, oAccB, 2'b00, oFlags}, {8'h00, 8'h00, 8'h28});
    chk("t5_unk_pc", oInstAddr, 8'h05);

    // Randomized instruction stream
    for (int k = 0; k < 40; k++)
      run_inst(mk(ops[$urandom_range(0, 23)], 8'($urandom)), int'($urandom_range(0, 3)));

    // 6: reset during EXEC discards the instruction
    do_reset();
    begin
      int n = 0;
      while (oInstReq !== 1'b1 && n < 10) begin @(posedge iClock); #1; n++; end
      chk("t6_req", oInstReq, 1);
    end
    iInstValid = 1'b1; iInstData = mk(OP_ADDCA, 8'h07);
    @(posedge iClock); #1;              // now DECODE
    iInstValid = 1'b0;
    @(posedge iClock); #1;              // now EXEC
    chk("t6_exec_sel", oAluInstSel, OP_ADDCA);
    iReset = 1'b0;
    @(posedge iClock); #1;
    iReset = 1'b1;
    chk("t6_A", oAccA, 8'h00);
    chk("t6_pc", oInstAddr, 8'h00);
    chk("t6_req_low", oInstReq, 0);
    saw_done = oInstDone;
    @(posedge iClock); #1;
    chk("t6_fetch_req", oInstReq, 1);
    repeat (6) begin
      saw_done = saw_done | oInstDone;
      @(posedge iClock); #1;
    end
    chk("t6_no_done", saw_done, 0);
    chk("t6_A_final", oAccA, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
